axi_rd_line_collector: RTL

Client-side read front end for `axi_shim`. Accepts one read request, issues it on the shim read-request port, and collects the returned AXI beats into a cache-line buffer. It then presents the whole line, with an exclusive-okay summary and an error flag, to the consumer. The block holds one outstanding transaction at a time and sits between the cache miss unit and `axi_shim`.

---
 rtl/axi_rd_line_collector.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/axi_rd_line_collector.sv
// axi_rd_line_collector
//   Read front end for axi_shim. Takes one client read request, forwards it
//   on the shim read-request port, gathers the returned beats into a line
//   buffer and hands the whole line to the consumer. One transaction is in
//   flight at a time.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / gnt_o          client request; gnt_o high whenever idle
//   addr_i .. lock_i       request fields, latched on req_i && gnt_o
//   rd_req_o / rd_gnt_i    shim request handshake, fields from latched copy
//   rd_rdy_o / rd_valid_i  shim beat handshake plus last/exokay/data/user/id
//   line_valid_o / line_ready_i  assembled line handshake plus line_* fields
//   drop_o                 one-cycle pulse when a beat with a foreign ID is sunk
//   dbg_state_o            current FSM state (IDLE=0, REQ=1, COLLECT=2, DELIVER=3)
//
// Handshakes: every interface transfers on a cycle where valid and ready are
// both high; the side that raised valid keeps its payload stable until then.
module axi_rd_line_collector #(
  parameter int AxiAddrWidth = 64,
  parameter int AxiDataWidth = 64,
  parameter int AxiUserWidth = 64,
  parameter int AxiIdWidth   = 4,
  parameter int AxiNumWords  = 4,
  localparam int BW          = $clog2(AxiNumWords)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_i,
  output logic                                gnt_o,
  input  logic [AxiAddrWidth-1:0]             addr_i,
  input  logic [BW-1:0]                       blen_i,
  input  logic [2:0]                          size_i,
  input  logic [AxiIdWidth-1:0]               id_i,
  input  logic                                lock_i,
  output logic                                line_valid_o,
  input  logic                                line_ready_i,
  output logic [AxiNumWords*AxiDataWidth-1:0] line_data_o,
  output logic [AxiNumWords*AxiUserWidth-1:0] line_user_o,
  output logic [AxiIdWidth-1:0]               line_id_o,
  output logic                                line_exokay_o,
  output logic                                line_err_o,
  output logic                                drop_o,
  output logic                                rd_req_o,
  output logic [AxiAddrWidth-1:0]             rd_addr_o,
  output logic [BW-1:0]                       rd_blen_o,
  output logic [2:0]                          rd_size_o,
  output logic [AxiIdWidth-1:0]               rd_id_o,
  output logic                                rd_lock_o,
  input  logic                                rd_gnt_i,
  output logic                                rd_rdy_o,
  input  logic                                rd_valid_i,
  input  logic                                rd_last_i,
  input  logic                                rd_exokay_i,
  input  logic [AxiDataWidth-1:0]             rd_data_i,
  input  logic [AxiUserWidth-1:0]             rd_user_i,
  input  logic [AxiIdWidth-1:0]               rd_id_i,
  output logic [1:0]                          dbg_state_o
);

  localparam int CW = BW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COLLECT = 2'd2, DELIVER = 2'd3} state_e;

  state_e state_q, state_d;

  logic [AxiAddrWidth-1:0] addr_q;
  logic [BW-1:0]           blen_q;
  logic [2:0]              size_q;
  logic [AxiIdWidth-1:0]   id_q;
  logic                    lock_q;
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
  logic                    exok_q;
  logic [AxiNumWords-1:0][AxiDataWidth-1:0] data_q;
  logic [AxiNumWords-1:0][AxiUserWidth-1:0] user_q;

  logic take_req;
  logic beat_hit;
  logic beat_fit;
  logic [CW-1:0] blen_ext;

  assign blen_ext = {1'b0, blen_q};
  assign take_req = (state_q == IDLE) && req_i;
  assign beat_hit = (state_q == COLLECT) && rd_valid_i && (rd_id_i == id_q);
  // cnt_q stops at blen_q+1, so any further matching beat lands here as overflow.
  assign beat_fit = (cnt_q <= blen_ext);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    gnt_o        = 1'b0;
    rd_req_o     = 1'b0;
    rd_rdy_o     = 1'b0;
    line_valid_o = 1'b0;
    drop_o       = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = 1'b1;
        if (req_i) state_d = REQ;
      end
      REQ: begin
        rd_req_o = 1'b1;
        if (rd_gnt_i) state_d = COLLECT;
      end
      COLLECT: begin
        rd_rdy_o = 1'b1;
        if (rd_valid_i) begin
          if (rd_id_i == id_q) begin
            if (rd_last_i) state_d = DELIVER;
          end else begin
            drop_o = 1'b1;
          end
        end
      end
      DELIVER: begin
        line_valid_o = 1'b1;
        if (line_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      blen_q <= '0;
      size_q <= '0;
      id_q   <= '0;
      lock_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      exok_q <= 1'b0;
      data_q <= '0;
      user_q <= '0;
    end else if (take_req) begin
      addr_q <= addr_i;
      blen_q <= blen_i;
      size_q <= size_i;
      id_q   <= id_i;
      lock_q <= lock_i;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      exok_q <= 1'b1;
      data_q <= '0;
      user_q <= '0;
    end else if (beat_hit) begin
      if (beat_fit) begin
        if (cnt_q < CW'(AxiNumWords)) begin
          data_q[cnt_q[BW-1:0]] <= rd_data_i;
          user_q[cnt_q[BW-1:0]] <= rd_user_i;
        end
        exok_q <= exok_q & rd_exokay_i;
        cnt_q  <= cnt_q + CW'(1);
      end
      // Count mismatch at the last beat uses the pre-increment count;
      // an overflow beat is an error on its own.
      if (!beat_fit || (rd_last_i && (cnt_q != blen_ext))) err_q <= 1'b1;
    end
  end

  assign rd_addr_o     = addr_q;
  assign rd_blen_o     = blen_q;
  assign rd_size_o     = size_q;
  assign rd_id_o       = id_q;
  assign rd_lock_o     = lock_q;
  assign line_data_o   = data_q;
  assign line_user_o   = user_q;
  assign line_id_o     = id_q;
  assign line_err_o    = err_q;
  assign line_exokay_o = exok_q && !err_q;
  assign dbg_state_o   = state_q;

endmodule
